// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap controller:
// CSR addresses, cause codes, mstatus bit positions and the commit action type.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] ECALL_M  = 32'd11;
    localparam logic [31:0] IRQ_BASE = 32'h8000_0010;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // What the committing EX instruction does this cycle, after priority.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_INT,
        ACT_ECALL,
        ACT_MRET,
        ACT_CSR
    } action_e;

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector and sticky pending latch for the external interrupt lines.
// A clear in the same cycle as a new edge on that line wins.
module irq_edge_latch #(
    parameter int NUM_IRQ = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] clr,
    output logic [NUM_IRQ-1:0] pend
);

    logic [NUM_IRQ-1:0] irq_q_reg;
    logic [NUM_IRQ-1:0] pend_reg;
    logic [NUM_IRQ-1:0] pend_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            assign pend_next[gi] = (pend_reg[gi] | (irq[gi] & ~irq_q_reg[gi])) & ~clr[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q_reg <= '0;
            pend_reg  <= '0;
        end else begin
            irq_q_reg <= irq;
            pend_reg  <= pend_next;
        end
    end

    assign pend = pend_reg;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: CSR read-modify-write, interrupt
// arbitration, ecall/mret handling and front-end redirect/flush generation.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int          NUM_IRQ     = 3,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic               stall,
    input  logic [31:0]        pc_ex,
    input  logic               ecall,
    input  logic               CSRRSI,
    input  logic               CSRRCI,
    input  logic               CSRRW,
    input  logic               mret,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        rs1_data,
    input  logic [4:0]         zimm,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        csr_rdata,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               suppress
);

    logic               mie_bit_reg, mie_bit_next;
    logic               mpie_reg, mpie_next;
    logic [NUM_IRQ-1:0] mie_reg, mie_next;
    logic [31:0]        mtvec_reg, mtvec_next;
    logic [31:0]        mepc_reg, mepc_next;
    logic [31:0]        mcause_reg, mcause_next;

    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] irq_act;
    logic [NUM_IRQ-1:0] int_clr;
    logic [2:0]         int_idx;
    logic               fire, csr_op, take_int;
    logic [31:0]        mstatus_val, old_val, wdata;
    action_e            action;

    assign fire     = instr_valid & ~stall;
    assign csr_op   = CSRRW | CSRRSI | CSRRCI;
    assign irq_act  = pend & mie_reg;
    assign take_int = fire & mie_bit_reg & (|irq_act);

    always_comb begin
        int_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_act[i]) int_idx = 3'(i);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
            assign int_clr[gi] = take_int & (int_idx == 3'(gi));
        end
    endgenerate

    irq_edge_latch #(.NUM_IRQ(NUM_IRQ)) u_irq_edge_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .irq   (irq),
        .clr   (int_clr),
        .pend  (pend)
    );

    always_comb begin
        action = ACT_NONE;
        if (fire) begin
            if (take_int)    action = ACT_INT;
            else if (ecall)  action = ACT_ECALL;
            else if (mret)   action = ACT_MRET;
            else if (csr_op) action = ACT_CSR;
        end
    end

    always_comb begin
        mstatus_val               = '0;
        mstatus_val[MSTATUS_MIE]  = mie_bit_reg;
        mstatus_val[MSTATUS_MPIE] = mpie_reg;
        case (csr_addr)
            CSR_MSTATUS: old_val = mstatus_val;
            CSR_MIE:     old_val = 32'(mie_reg);
            CSR_MTVEC:   old_val = mtvec_reg;
            CSR_MEPC:    old_val = mepc_reg;
            CSR_MCAUSE:  old_val = mcause_reg;
            CSR_MIP:     old_val = 32'(pend);
            default:     old_val = '0;
        endcase
        wdata = old_val;
        if (CSRRW)       wdata = rs1_data;
        else if (CSRRSI) wdata = old_val | {27'b0, zimm};
        else if (CSRRCI) wdata = old_val & ~{27'b0, zimm};
    end

    always_comb begin
        mie_bit_next = mie_bit_reg;
        mpie_next    = mpie_reg;
        mie_next     = mie_reg;
        mtvec_next   = mtvec_reg;
        mepc_next    = mepc_reg;
        mcause_next  = mcause_reg;
        case (action)
            ACT_INT: begin
                mepc_next    = pc_ex & ~32'h3;
                mcause_next  = IRQ_BASE + 32'(int_idx);
                mpie_next    = mie_bit_reg;
                mie_bit_next = 1'b0;
            end
            ACT_ECALL: begin
                mepc_next    = pc_ex & ~32'h3;
                mcause_next  = ECALL_M;
                mpie_next    = mie_bit_reg;
                mie_bit_next = 1'b0;
            end
            ACT_MRET: begin
                mie_bit_next = mpie_reg;
                mpie_next    = 1'b1;
            end
            ACT_CSR: begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie_bit_next = wdata[MSTATUS_MIE];
                        mpie_next    = wdata[MSTATUS_MPIE];
                    end
                    CSR_MIE:    mie_next    = wdata[NUM_IRQ-1:0];
                    CSR_MTVEC:  mtvec_next  = wdata & ~32'h3;
                    CSR_MEPC:   mepc_next   = wdata & ~32'h3;
                    CSR_MCAUSE: mcause_next = wdata;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_bit_reg <= 1'b0;
            mpie_reg    <= 1'b0;
            mie_reg     <= '0;
            mtvec_reg   <= MTVEC_RESET & ~32'h3;
            mepc_reg    <= '0;
            mcause_reg  <= '0;
        end else begin
            mie_bit_reg <= mie_bit_next;
            mpie_reg    <= mpie_next;
            mie_reg     <= mie_next;
            mtvec_reg   <= mtvec_next;
            mepc_reg    <= mepc_next;
            mcause_reg  <= mcause_next;
        end
    end

    // The old value is still presented when an interrupt squashes a CSR op;
    // suppress keeps it from reaching rd.
    assign csr_rdata   = (rst_n & fire & csr_op) ? old_val : 32'h0;
    assign redirect    = rst_n & ((action == ACT_INT) | (action == ACT_ECALL) | (action == ACT_MRET));
    assign redirect_pc = !rst_n                  ? 32'h0 :
                         (action == ACT_MRET)    ? mepc_reg :
                         (action == ACT_INT || action == ACT_ECALL) ? mtvec_reg : 32'h0;
    assign suppress    = rst_n & (action == ACT_INT);

endmodule
